// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670 capture front end and the VGA address generator.
package cam_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_FRM = 2'd1,
      CAPTURE  = 2'd2
   } state_e;

   localparam int H_PIXELS_DEF = 640;
   localparam int V_LINES_DEF  = 480;
   localparam int ADDR_W_DEF   = 19;

   localparam int RGB_R_MSB = 11;
   localparam int RGB_R_LSB = 8;
   localparam int RGB_G_MSB = 7;
   localparam int RGB_G_LSB = 4;
   localparam int RGB_B_MSB = 3;
   localparam int RGB_B_LSB = 0;

   function automatic logic [11:0] pack_rgb444(input logic [3:0] r,
                                               input logic [3:0] g,
                                               input logic [3:0] b);
      logic [11:0] px;
      px = 12'h000;
      px[RGB_R_MSB:RGB_R_LSB] = r;
      px[RGB_G_MSB:RGB_G_LSB] = g;
      px[RGB_B_MSB:RGB_B_LSB] = b;
      return px;
   endfunction

endpackage

// File: rtl/cam_capture_if.sv
// Camera bus inputs and frame-buffer write-port outputs of the capture block.
interface cam_capture_if
   import cam_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
);
   logic              i_cfg_done;
   logic              i_cam_vsync;
   logic              i_cam_href;
   logic [7:0]        i_cam_data;
   logic              o_wr_en;
   logic [ADDR_W-1:0] o_wr_addr;
   logic [11:0]       o_wr_data;
   logic              o_frame_done;
   logic              o_busy;

   modport master (
      output i_cfg_done, i_cam_vsync, i_cam_href, i_cam_data,
      input  o_wr_en, o_wr_addr, o_wr_data, o_frame_done, o_busy
   );

   modport slave (
      input  i_cfg_done, i_cam_vsync, i_cam_href, i_cam_data,
      output o_wr_en, o_wr_addr, o_wr_data, o_frame_done, o_busy
   );
endinterface

// File: rtl/cam_capture.sv
// OV7670 capture: pairs camera bytes into RGB444 pixels and writes them linearly
// into the frame BRAM, entirely in the PCLK domain.
module cam_capture
   import cam_pkg::*;
#(
   parameter int H_PIXELS = H_PIXELS_DEF,
   parameter int V_LINES  = V_LINES_DEF,
   parameter int ADDR_W   = ADDR_W_DEF
)(
   input  logic          i_pclk,
   input  logic          i_rst_pclk,
   cam_capture_if.slave  bus
);
   localparam int XW = $clog2(H_PIXELS + 1);
   localparam int YW = $clog2(V_LINES + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_PIXELS * V_LINES - 1);

   state_e            state_q, state_d;
   logic              s1_vsync_q, s1_href_q, vsync_prev_q, href_prev_q;
   logic [7:0]        s1_data_q;
   logic              phase_q, phase_d, seen_q, seen_d;
   logic [3:0]        r_q, r_d;
   logic [XW-1:0]     x_q, x_d;
   logic [YW-1:0]     y_q, y_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wr_en_q, wr_en_d, frame_done_q, frame_done_d, busy_q, busy_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [11:0]       wr_data_q, wr_data_d;
   logic              vs_fall_s, vs_rise_s, href_fall_s;

   assign vs_fall_s   = !s1_vsync_q &&  vsync_prev_q;
   assign vs_rise_s   =  s1_vsync_q && !vsync_prev_q;
   assign href_fall_s = !s1_href_q  &&  href_prev_q;

   always_ff @(posedge i_pclk or posedge i_rst_pclk) begin
      if (i_rst_pclk) begin
         s1_vsync_q   <= 1'b0;
         s1_href_q    <= 1'b0;
         s1_data_q    <= 8'h00;
         vsync_prev_q <= 1'b0;
         href_prev_q  <= 1'b0;
      end else begin
         s1_vsync_q   <= bus.i_cam_vsync;
         s1_href_q    <= bus.i_cam_href;
         s1_data_q    <= bus.i_cam_data;
         vsync_prev_q <= s1_vsync_q;
         href_prev_q  <= s1_href_q;
      end
   end

   always_ff @(posedge i_pclk or posedge i_rst_pclk) begin
      if (i_rst_pclk) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Losing cfg_done aborts from any state; a frame is only entered at its start.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.i_cfg_done) state_d = WAIT_FRM;
            else                state_d = IDLE;
         end
         WAIT_FRM: begin
            if (!bus.i_cfg_done) state_d = IDLE;
            else if (vs_fall_s)  state_d = CAPTURE;
            else                 state_d = WAIT_FRM;
         end
         CAPTURE: begin
            if (!bus.i_cfg_done) state_d = IDLE;
            else if (vs_rise_s)  state_d = WAIT_FRM;
            else                 state_d = CAPTURE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      phase_d      = phase_q;
      seen_d       = seen_q;
      r_d          = r_q;
      x_d          = x_q;
      y_d          = y_q;
      addr_d       = addr_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      frame_done_d = 1'b0;
      busy_d       = (state_d == CAPTURE);
      if (state_q == WAIT_FRM && state_d == CAPTURE) begin
         phase_d = 1'b0;
         seen_d  = 1'b0;
         x_d     = '0;
         y_d     = '0;
         addr_d  = '0;
      end else if (state_q == CAPTURE && state_d == CAPTURE) begin
         if (s1_href_q) begin
            seen_d = 1'b1;
            if (!phase_q) begin
               phase_d = 1'b1;
               r_d     = s1_data_q[3:0];
            end else begin
               phase_d = 1'b0;
               // Out-of-range pixels still complete the pair but never reach the BRAM.
               if (x_q < XW'(H_PIXELS) && y_q < YW'(V_LINES)) begin
                  wr_en_d      = 1'b1;
                  wr_addr_d    = addr_q;
                  wr_data_d    = pack_rgb444(r_q, s1_data_q[7:4], s1_data_q[3:0]);
                  frame_done_d = (addr_q == LAST_ADDR);
                  addr_d       = addr_q + ADDR_W'(1);
               end else begin
                  wr_en_d = 1'b0;
               end
               if (x_q < XW'(H_PIXELS)) x_d = x_q + XW'(1);
               else                     x_d = x_q;
            end
         end else begin
            phase_d = 1'b0;
            if (href_fall_s) begin
               x_d    = '0;
               seen_d = 1'b0;
               if (seen_q && y_q < YW'(V_LINES)) y_d = y_q + YW'(1);
               else                              y_d = y_q;
            end else begin
               x_d = x_q;
            end
         end
      end else begin
         phase_d = phase_q;
      end
   end

   always_ff @(posedge i_pclk or posedge i_rst_pclk) begin
      if (i_rst_pclk) begin
         phase_q      <= 1'b0;
         seen_q       <= 1'b0;
         r_q          <= 4'h0;
         x_q          <= '0;
         y_q          <= '0;
         addr_q       <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= 12'h000;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         phase_q      <= phase_d;
         seen_q       <= seen_d;
         r_q          <= r_d;
         x_q          <= x_d;
         y_q          <= y_d;
         addr_q       <= addr_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.o_wr_en      = wr_en_q;
   assign bus.o_wr_addr    = wr_addr_q;
   assign bus.o_wr_data    = wr_data_q;
   assign bus.o_frame_done = frame_done_q;
   assign bus.o_busy       = busy_q;

endmodule
